// File: rtl/uart_echo_pkg.sv
// Shared encodings for the UART echo engine: FSM states, echo modes and ASCII constants.

package uart_echo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      EMIT     = 2'd2,
      TERM_OUT = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_UPPER = 2'b01,
      MODE_LINE  = 2'b10,
      MODE_REV   = 2'b11
   } mode_e;

   localparam logic [7:0] ASCII_LOWER_A   = 8'h61;
   localparam logic [7:0] ASCII_LOWER_Z   = 8'h7A;
   localparam logic [7:0] ASCII_CASE_DIFF = 8'h20;

endpackage

// File: rtl/uart_echo_if.sv
// FIFO-side handshake bundle: RX FIFO read port and TX FIFO write port.
// master = echo engine, slave = FIFO side.

interface uart_echo_if #(
   parameter int unsigned DBITS = 8
);
   logic             rx_empty;
   logic [DBITS-1:0] rx_data;
   logic             rd_uart;
   logic             tx_full;
   logic             wr_uart;
   logic [DBITS-1:0] tx_data;

   modport master (
      input  rx_empty, rx_data, tx_full,
      output rd_uart, wr_uart, tx_data
   );

   modport slave (
      output rx_empty, rx_data, tx_full,
      input  rd_uart, wr_uart, tx_data
   );
endinterface

// File: rtl/echo_line_buf.sv
// Line buffer: LINE_DEPTH x DBITS register array, one synchronous write port,
// one asynchronous read port.

module echo_line_buf #(
   parameter int unsigned DBITS      = 8,
   parameter int unsigned LINE_DEPTH = 64,
   parameter int unsigned LINE_AW    = 6
) (
   input  logic               clk,
   input  logic               we,
   input  logic [LINE_AW-1:0] waddr,
   input  logic [DBITS-1:0]   wdata,
   input  logic [LINE_AW-1:0] raddr,
   output logic [DBITS-1:0]   rdata
);

   logic [DBITS-1:0] mem [LINE_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_echo_engine.sv
// Echo engine between RX FIFO and TX FIFO: pass, upper-case, line and reversed-line modes.
// Optional statistics counters enabled by the UART_ECHO_STATS_EN macro.

module uart_echo_engine
   import uart_echo_pkg::*;
#(
   parameter int unsigned DBITS      = 8,
   parameter int unsigned LINE_DEPTH = 64,
   parameter int unsigned LINE_AW    = 6,
   parameter logic [7:0]  TERM       = 8'h0D,
   parameter int unsigned CNT_BITS   = 16
) (
   input  logic                clk_100MHz,
   input  logic                reset_btn,
   input  logic [1:0]          mode,
   uart_echo_if.master         fifo,
   output logic                busy,
`ifdef UART_ECHO_STATS_EN
   output logic [CNT_BITS-1:0] rx_count,
   output logic [CNT_BITS-1:0] tx_count,
`endif
   output logic                line_ovf
);

   localparam logic [DBITS-1:0] TermW = DBITS'(TERM);
   localparam logic [LINE_AW:0] Full  = (LINE_AW + 1)'(LINE_DEPTH);

   state_e             state_q, state_d;
   mode_e              mode_q, mode_eff;
   logic [LINE_AW:0]   cnt_q, cnt_d;
   logic [LINE_AW-1:0] idx_q, idx_d;
   logic [DBITS-1:0]   byte_q, byte_d;
   logic [DBITS-1:0]   up_data, buf_rdata, txd;
   logic               busy_q, line_ovf_q, ovf, buf_we, rd, wr, rev, last;

   // The new mode only takes effect between lines, including for the word popped now.
   assign mode_eff = (state_q == IDLE && cnt_q == '0) ? mode_e'(mode) : mode_q;
   assign rev      = (mode_eff == MODE_REV);
   assign last     = rev ? (idx_q == '0) : ({1'b0, idx_q} == cnt_q - 1'b1);

   always_comb begin
      up_data = fifo.rx_data;
      if (DBITS == 8 && fifo.rx_data >= DBITS'(ASCII_LOWER_A) &&
          fifo.rx_data <= DBITS'(ASCII_LOWER_Z)) begin
         up_data = fifo.rx_data - DBITS'(ASCII_CASE_DIFF);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      rd      = 1'b0;
      wr      = 1'b0;
      txd     = byte_q;
      buf_we  = 1'b0;
      ovf     = 1'b0;
      unique case (state_q)
         IDLE: begin
            rd = ~fifo.rx_empty;
            if (!fifo.rx_empty) begin
               if (mode_eff == MODE_PASS || mode_eff == MODE_UPPER) begin
                  byte_d  = (mode_eff == MODE_UPPER) ? up_data : fifo.rx_data;
                  state_d = HOLD;
               end else if (fifo.rx_data != TermW) begin
                  buf_we = 1'b1;
                  cnt_d  = cnt_q + 1'b1;
                  if (cnt_d == Full) begin
                     ovf     = 1'b1;
                     state_d = EMIT;
                     idx_d   = rev ? LINE_AW'(LINE_DEPTH - 1) : '0;
                  end
               end else begin
                  state_d = (cnt_q != '0) ? EMIT : TERM_OUT;
                  idx_d   = rev ? LINE_AW'(cnt_q - 1'b1) : '0;
               end
            end
         end
         HOLD: begin
            wr = ~fifo.tx_full;
            if (!fifo.tx_full) state_d = IDLE;
         end
         EMIT: begin
            txd = buf_rdata;
            wr  = ~fifo.tx_full;
            if (!fifo.tx_full) begin
               if (last) state_d = TERM_OUT;
               else      idx_d   = rev ? idx_q - 1'b1 : idx_q + 1'b1;
            end
         end
         TERM_OUT: begin
            txd = TermW;
            wr  = ~fifo.tx_full;
            if (!fifo.tx_full) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_100MHz) begin
      if (reset_btn) begin
         state_q    <= IDLE;
         mode_q     <= MODE_PASS;
         cnt_q      <= '0;
         idx_q      <= '0;
         byte_q     <= '0;
         busy_q     <= 1'b0;
         line_ovf_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_eff;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         byte_q     <= byte_d;
         busy_q     <= (state_d != IDLE) || (cnt_d != '0);
         line_ovf_q <= ovf;
      end
   end

   echo_line_buf #(
      .DBITS      (DBITS),
      .LINE_DEPTH (LINE_DEPTH),
      .LINE_AW    (LINE_AW)
   ) u_line_buf (
      .clk   (clk_100MHz),
      .we    (buf_we),
      .waddr (cnt_q[LINE_AW-1:0]),
      .wdata (fifo.rx_data),
      .raddr (idx_q),
      .rdata (buf_rdata)
   );

   assign fifo.rd_uart = rd & ~reset_btn;
   assign fifo.wr_uart = wr & ~reset_btn;
   assign fifo.tx_data = txd;
   assign busy         = busy_q;
   assign line_ovf     = line_ovf_q;

`ifdef UART_ECHO_STATS_EN
   logic [CNT_BITS-1:0] rx_cnt_q, tx_cnt_q;

   always_ff @(posedge clk_100MHz) begin
      if (reset_btn) begin
         rx_cnt_q <= '0;
         tx_cnt_q <= '0;
      end else begin
         rx_cnt_q <= rx_cnt_q + CNT_BITS'(fifo.rd_uart);
         tx_cnt_q <= tx_cnt_q + CNT_BITS'(fifo.wr_uart);
      end
   end

   assign rx_count = rx_cnt_q;
   assign tx_count = tx_cnt_q;
`else
   logic unused_cnt_bits;
   assign unused_cnt_bits = ^CNT_BITS;
`endif

endmodule

// File: doc/uart_echo_engine.md
# uart_echo_engine

Parametrised successor to the automated UART loopback controller. It sits between the RX FIFO read side and the TX FIFO write side of the UART system. It echoes received words with a runtime-selectable mode: pass-through, upper-case, line-buffered, or line-reversed. It respects TX FIFO back-pressure, which the first-generation loopback ignored.

## Interface
- DBITS, 8, word width; must match the UART FIFOs
- LINE_DEPTH, 64, line-buffer entries, power of two, at least 2
- LINE_AW, 6, line-buffer address width; equals $clog2(LINE_DEPTH)
- TERM, 8'h0D, line terminator word; truncated to DBITS
- CNT_BITS, 16, statistics counter width; only used with the stats macro

Ports (one clock; reset is synchronous and active-high):
- clk_100MHz  in  1  system clock
- reset_btn  in  1  synchronous active-high reset
- mode  in  2  00 PASS, 01 UPPER, 10 LINE, 11 REVERSE
- rx_empty  in  1  RX FIFO empty
- rx_data  in  DBITS  RX FIFO head word; first-word fall-through, valid while rx_empty=0
- rd_uart  out  1  RX pop strobe; combinational
- tx_full  in  1  TX FIFO full
- wr_uart  out  1  TX push strobe; combinational
- tx_data  out  DBITS  TX write data; combinational, valid when wr_uart=1
- busy  out  1  registered; 1 when state is not IDLE or line count is not 0
- line_ovf  out  1  registered one-cycle pulse on line-buffer overflow flush
- rx_count, tx_count  out  CNT_BITS  stats counters; present only with the stats macro

## Operation
- FSM states: IDLE, HOLD, EMIT, TERM_OUT. Line count cnt has range 0..LINE_DEPTH.
- Mode latching: mode_q <= mode only in IDLE with cnt==0. mode_q stays fixed while a line is partially collected.
- IDLE, all modes: rd_uart = ~rx_empty. The word is consumed in the same cycle it is popped.
- IDLE, PASS/UPPER:
  - byte_q <= f(rx_data), then go to HOLD.
  - For UPPER with DBITS==8, f maps 0x61..0x7A to the value minus 0x20. Otherwise f is identity.
- HOLD: wr_uart = ~tx_full, tx_data = byte_q. Go to IDLE on the cycle tx_full=0.
- IDLE, LINE/REVERSE:
  - If the word is not TERM: write it to buf[cnt], cnt++. If cnt becomes LINE_DEPTH, pulse line_ovf and go to EMIT.
  - If the word is TERM: go to EMIT if cnt>0, else go to TERM_OUT.
- EMIT:
  - idx starts at 0 for LINE, or cnt-1 for REVERSE.
  - On each cycle with tx_full=0: wr_uart=1, tx_data=buf[idx], then step idx (up for LINE, down for REVERSE).
  - After cnt words have been emitted, go to TERM_OUT.
- TERM_OUT: wr_uart = ~tx_full, tx_data = TERM. On write: cnt <= 0, go to IDLE.
- rd_uart is 0 outside IDLE. RX is back-pressured, so the RX FIFO may fill during long emits; this is accepted.
- Overflow: the flushed line is still followed by TERM. The next received word starts a new line.

## Timing
- Reset values: state IDLE, cnt 0, mode_q 00, busy 0, line_ovf 0, counters 0. rd_uart and wr_uart are forced to 0 while reset_btn=1.
- Reset mid-line or mid-emit: the buffered line is discarded and no TERM is sent.
- PASS/UPPER latency:
  - Pop in cycle N, wr_uart in cycle N+1 if tx_full=0.
  - Peak throughput is one word per 2 cycles.
- LINE/REVERSE:
  - Emission starts the cycle after TERM is popped (or after the overflow write).
  - Words go out one per cycle while tx_full=0.
  - A line of k words occupies k+1 TX writes.
- tx_full stalls freeze idx and tx_data. No word is lost or duplicated.
- Simultaneous mode change during a line: ignored until the line is complete.

## Configuration
- Macro: UART_ECHO_STATS_EN.
- Defined:
  - rx_count increments on every rd_uart.
  - tx_count increments on every wr_uart.
  - Both wrap modulo 2^CNT_BITS and reset to 0.
- Undefined: the rx_count/tx_count ports and the counter logic are absent; all other behaviour is identical.

## Structure
- Package uart_echo_pkg holds:
  - state encodings IDLE/HOLD/EMIT/TERM_OUT
  - mode encodings MODE_PASS/MODE_UPPER/MODE_LINE/MODE_REV
  - ASCII constants 0x61, 0x7A, 0x20
- Sub-module echo_line_buf: LINE_DEPTH x DBITS register array, synchronous write, asynchronous read, one write port and one read port.

## Test plan
- PASS: push 0x61 with tx_full=0 -> rd_uart in cycle N; wr_uart with tx_data=0x61 in cycle N+1.
- UPPER: push 0x61, 0x7A, 0x41, 0x7B -> TX sees 0x41, 0x5A, 0x41, 0x7B.
- LINE then REVERSE:
  - LINE: push 0x41, 0x42, 0x0D -> no writes until 0x0D is popped, then 0x41, 0x42, 0x0D on consecutive cycles.
  - REVERSE: push 0x31, 0x32, 0x33, 0x0D -> TX sees 0x33, 0x32, 0x31, 0x0D.
- Back-pressure:
  - Hold tx_full=1 for 5 cycles in HOLD -> wr_uart=0 throughout, then exactly one write of the held word.
  - Repeat mid-EMIT -> output order is unchanged.
- Overflow with LINE_DEPTH=4:
  - Push 0x31..0x35 with no TERM -> TX sees 0x31..0x34, 0x0D, and line_ovf pulses once.
  - 0x35 begins the next line.
- Reset mid-EMIT: reset_btn=1 for 1 cycle -> no further writes, busy=0, cnt=0. With UART_ECHO_STATS_EN defined, the counters read 0.
